// File: rtl/sobol_rng_pkg.sv
// Shared definitions for the Sobol sequence generator: width defaults,
// direction-vector type and the van der Corput reset table.
package sobol_rng_pkg;

    localparam int INWD_DEF = 8;
    localparam int INWD_MAX = 10;

    typedef logic [INWD_MAX-1:0] dir_vec_t;

    // Van der Corput direction k for a width-bit generator: a single bit
    // walking down from the MSB, so the sequence is the bit-reversed count.
    function automatic dir_vec_t vdc_dir(input int width, input int k);
        return dir_vec_t'(1) << (width - 1 - k);
    endfunction

endpackage

// File: rtl/sobol_rng_if.sv
// Control, direction-programming and output stream signals of sobol_rng.
interface sobol_rng_if
    import sobol_rng_pkg::*;
#(
    parameter int INWD    = INWD_DEF,
    parameter int LOGINWD = $clog2(INWD)
);

    logic               en;
    logic               clear;
    logic               dir_we;
    logic [LOGINWD-1:0] dir_addr;
    logic [INWD-1:0]    dir_wdata;
    logic               out_valid;
    logic               out_ready;
    logic [INWD-1:0]    out_rnd;
    logic               out_last;

    modport master (
        output en, clear, dir_we, dir_addr, dir_wdata, out_ready,
        input  out_valid, out_rnd, out_last
    );

    modport slave (
        input  en, clear, dir_we, dir_addr, dir_wdata, out_ready,
        output out_valid, out_rnd, out_last
    );

endinterface

// File: rtl/sobol_rng_lsz.sv
// Index of the least significant zero bit of a vector; returns 0 when the
// vector is all ones (callers detect that case separately).
module sobol_rng_lsz
    import sobol_rng_pkg::*;
#(
    parameter int WIDTH = INWD_DEF,
    parameter int IDXW  = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic [IDXW-1:0]  idx_o
);

    // NOTE: idx_o gets a default before the loop so every path assigns it;
    // without it this block would infer a latch.
    always_comb begin
        idx_o = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!vec_i[i]) begin
                idx_o = IDXW'(i);
            end
        end
    end

endmodule

// File: rtl/sobol_rng.sv
// Streaming Sobol sample generator: counter, programmable direction table
// and a valid/ready output register stage.
module sobol_rng
    import sobol_rng_pkg::*;
#(
    parameter int INWD    = INWD_DEF,
    parameter int LOGINWD = $clog2(INWD)
) (
    input  logic       clk,
    input  logic       rst,
    sobol_rng_if.slave bus
);

    logic [INWD-1:0]    dir_q [INWD];
    logic [INWD-1:0]    cnt_q, cnt_d;
    logic [INWD-1:0]    rnd_q, rnd_d;
    logic               valid_q, valid_d;
    logic               last_q, last_d;

    logic [INWD-1:0]    cnt_next;
    logic [INWD-1:0]    rnd_next;
    logic [LOGINWD-1:0] lsz;
    logic               all_ones;
    logic               xfer;
    logic [31:0]        addr_ext;
    logic               addr_ok;

    sobol_rng_lsz #(
        .WIDTH (INWD),
        .IDXW  (LOGINWD)
    ) u_lsz (
        .vec_i (cnt_q),
        .idx_o (lsz)
    );

    assign all_ones = &cnt_q;
    assign xfer     = valid_q && bus.out_ready;
    assign addr_ext = 32'(bus.dir_addr);
    assign addr_ok  = addr_ext < 32'(INWD);

    always_comb begin
        if (all_ones) begin
            cnt_next = '0;
            rnd_next = '0;
        end else begin
            cnt_next = cnt_q + INWD'(1);
            rnd_next = rnd_q ^ dir_q[lsz];
        end
    end

    // clear outranks a transfer; a held sample stays put until accepted.
    always_comb begin
        cnt_d   = cnt_q;
        rnd_d   = rnd_q;
        valid_d = valid_q;
        if (bus.clear) begin
            cnt_d   = '0;
            rnd_d   = '0;
            valid_d = 1'b0;
        end else if (xfer) begin
            cnt_d   = cnt_next;
            rnd_d   = rnd_next;
            valid_d = bus.en;
        end else if (!valid_q && bus.en) begin
            valid_d = 1'b1;
        end
        last_d = (&cnt_d) && valid_d;
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            rnd_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            rnd_q   <= rnd_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    // NOTE: the direction table is a register file, not a RAM, so it can and
    // must be reset: the sequence has to be usable without programming.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < INWD; k++) begin
                dir_q[k] <= INWD'(vdc_dir(INWD, k));
            end
        end else if (bus.dir_we && addr_ok) begin
            dir_q[bus.dir_addr] <= bus.dir_wdata;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_rnd   = rnd_q;
    assign bus.out_last  = last_q;

endmodule

// File: tb/tb_sobol_rng.sv
// Bench for sobol_rng at INWD=3 and INWD=8: directed scenarios plus random
// handshake traffic against a Gray-code model of the Sobol sequence.
module tb_sobol_rng;

    logic clk = 1'b0;
    logic rst3;
    logic rst8;

    always #5 clk = ~clk;

    sobol_rng_if #(.INWD(3)) if3 ();
    sobol_rng_if #(.INWD(8)) if8 ();

    sobol_rng #(.INWD(3)) dut3 (.clk(clk), .rst(rst3), .bus(if3.slave));
    sobol_rng #(.INWD(8)) dut8 (.clk(clk), .rst(rst8), .bus(if8.slave));

    int n_checks = 0;
    int n_fail   = 0;

    // Model state per DUT: sample index in the period, valid flag, table.
    int wd [2] = '{3, 8};
    bit m_valid [2];
    int m_idx [2];
    int m_dir [2][10];
    bit stale [2];

    int seq1 [10] = '{0, 4, 6, 2, 3, 7, 5, 1, 0, 4};
    int seq3 [9]  = '{0, 1, 3, 2, 6, 7, 5, 4, 0};
    bit seen [256];

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Sobol sample n = XOR of the directions selected by the bits of gray(n).
    function automatic int sobol(input int d, input int n);
        int g = n ^ (n >> 1);
        int r = 0;
        for (int k = 0; k < wd[d]; k++) begin
            if (g[k]) r ^= m_dir[d][k];
        end
        return r;
    endfunction

    task automatic model_step(input int d, input bit r, input bit e, input bit c,
                              input bit we, input int a, input int wv, input bit rdy);
        if (r) begin
            m_valid[d] = 1'b0;
            m_idx[d]   = 0;
            for (int k = 0; k < wd[d]; k++) m_dir[d][k] = 1 << (wd[d] - 1 - k);
        end else begin
            if (c) begin
                m_valid[d] = 1'b0;
                m_idx[d]   = 0;
            end else if (m_valid[d] && rdy) begin
                m_idx[d]   = (m_idx[d] + 1) % (1 << wd[d]);
                m_valid[d] = e;
            end else if (!m_valid[d] && e) begin
                m_valid[d] = 1'b1;
            end
            if (we && a < wd[d]) m_dir[d][a] = wv;
        end
    endtask

    task automatic compare(input int d, input bit v, input int rnd, input bit last);
        string p = (d == 0) ? "d3" : "d8";
        check({p, "_valid"}, int'(v), int'(m_valid[d]));
        if (!stale[d]) check({p, "_rnd"}, rnd, sobol(d, m_idx[d]));
        check({p, "_last"}, int'(last),
              int'(m_valid[d] && (m_idx[d] == (1 << wd[d]) - 1)));
    endtask

    // One clock: capture inputs, advance, then check both DUTs 1 ns later.
    task automatic step();
        bit r0 = rst3;
        bit e0 = if3.en;
        bit c0 = if3.clear;
        bit w0 = if3.dir_we;
        bit y0 = if3.out_ready;
        int a0 = int'(if3.dir_addr);
        int v0 = int'(if3.dir_wdata);
        bit r1 = rst8;
        bit e1 = if8.en;
        bit c1 = if8.clear;
        bit w1 = if8.dir_we;
        bit y1 = if8.out_ready;
        int a1 = int'(if8.dir_addr);
        int v1 = int'(if8.dir_wdata);
        @(posedge clk);
        #1;
        model_step(0, r0, e0, c0, w0, a0, v0, y0);
        model_step(1, r1, e1, c1, w1, a1, v1, y1);
        compare(0, if3.out_valid, int'(if3.out_rnd), if3.out_last);
        compare(1, if8.out_valid, int'(if8.out_rnd), if8.out_last);
    endtask

    initial begin
        int distinct;
        int lasts;
        rst3 = 1'b1;
        rst8 = 1'b1;
        if3.en = 1'b0; if3.clear = 1'b0; if3.dir_we = 1'b0;
        if3.dir_addr = '0; if3.dir_wdata = '0; if3.out_ready = 1'b0;
        if8.en = 1'b0; if8.clear = 1'b0; if8.dir_we = 1'b0;
        if8.dir_addr = '0; if8.dir_wdata = '0; if8.out_ready = 1'b0;
        step();
        step();
        check("rst_valid", int'(if3.out_valid), 0);
        check("rst_rnd", int'(if3.out_rnd), 0);
        check("rst_last", int'(if3.out_last), 0);
        rst3 = 1'b0;
        rst8 = 1'b0;
        step();

        // Free-running van der Corput sequence.
        if3.en = 1'b1;
        if3.out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            check("s1_seq", int'(if3.out_rnd), seq1[k]);
            check("s1_last", int'(if3.out_last), int'(k == 7));
        end

        // Backpressure at sample 6.
        step();
        check("s2_at6", int'(if3.out_rnd), 6);
        if3.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("s2_hold_rnd", int'(if3.out_rnd), 6);
            check("s2_hold_valid", int'(if3.out_valid), 1);
        end
        if3.out_ready = 1'b1;
        step();
        check("s2_next", int'(if3.out_rnd), 2);

        // clear colliding with a transfer at sample 7.
        step();
        step();
        check("s4_at7", int'(if3.out_rnd), 7);
        if3.clear = 1'b1;
        step();
        check("s4_clr_valid", int'(if3.out_valid), 0);
        check("s4_clr_rnd", int'(if3.out_rnd), 0);
        if3.clear = 1'b0;
        step();
        check("s4_restart0", int'(if3.out_rnd), 0);
        step();
        check("s4_restart1", int'(if3.out_rnd), 4);
        step();
        check("s4_restart2", int'(if3.out_rnd), 6);

        // Program {001,010,100} while idle; address 3 is out of range.
        if3.en = 1'b0;
        step();
        if3.clear = 1'b1;
        step();
        if3.clear = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if3.dir_we    = 1'b1;
            if3.dir_addr  = 2'(k);
            if3.dir_wdata = (k < 3) ? 3'(1 << k) : 3'd7;
            step();
        end
        if3.dir_we = 1'b0;
        if3.en = 1'b1;
        step();
        check("s3_seq", int'(if3.out_rnd), seq3[0]);
        for (int k = 1; k < 9; k++) begin
            step();
            check("s3_seq", int'(if3.out_rnd), seq3[k]);
        end

        // A write in the same cycle as a transfer: old dir[0] is used.
        if3.dir_we    = 1'b1;
        if3.dir_addr  = 2'd0;
        if3.dir_wdata = 3'd5;
        stale[0] = 1'b1;
        step();
        check("s3_old_dir", int'(if3.out_rnd), 1);
        stale[0] = 1'b0;
        if3.dir_we = 1'b0;
        if3.clear = 1'b1;
        step();
        if3.clear = 1'b0;
        step();
        step();
        check("s3_new_dir", int'(if3.out_rnd), 5);

        // Reset mid-stream restores van der Corput.
        step();
        step();
        rst3 = 1'b1;
        step();
        check("s5_rst_valid", int'(if3.out_valid), 0);
        check("s5_rst_rnd", int'(if3.out_rnd), 0);
        rst3 = 1'b0;
        step();
        check("s5_seq", int'(if3.out_rnd), seq1[0]);
        for (int k = 1; k < 9; k++) begin
            step();
            check("s5_seq", int'(if3.out_rnd), seq1[k]);
        end

        // en falls while a sample waits for acceptance.
        if3.out_ready = 1'b0;
        if3.en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("s6_hold", int'(if3.out_valid), 1);
        end
        if3.out_ready = 1'b1;
        step();
        check("s6_drop", int'(if3.out_valid), 0);
        step();
        check("s6_idle", int'(if3.out_valid), 0);

        // Random traffic at INWD=3; table writes only while idle at index 0.
        for (int i = 0; i < 400; i++) begin
            if3.en        = ($urandom_range(3) != 0);
            if3.out_ready = ($urandom_range(4) > 1);
            if3.clear     = ($urandom_range(31) == 0);
            if3.dir_we    = 1'b0;
            if (!m_valid[0] && m_idx[0] == 0 && $urandom_range(3) == 0) begin
                if3.dir_we    = 1'b1;
                if3.dir_addr  = 2'($urandom_range(3));
                if3.dir_wdata = 3'($urandom_range(7));
            end
            step();
        end
        if3.en = 1'b0; if3.clear = 1'b0; if3.dir_we = 1'b0;

        // INWD=8: one full period must hold 256 distinct samples.
        if8.en = 1'b1;
        if8.out_ready = 1'b1;
        step();
        distinct = 0;
        lasts = 0;
        for (int j = 0; j < 256; j++) begin
            if (!seen[if8.out_rnd]) distinct++;
            seen[if8.out_rnd] = 1'b1;
            if (if8.out_last) lasts++;
            step();
        end
        check("d8_distinct", distinct, 256);
        check("d8_last_count", lasts, 1);
        check("d8_wrap", int'(if8.out_rnd), 0);

        for (int i = 0; i < 600; i++) begin
            if8.en        = ($urandom_range(7) != 0);
            if8.out_ready = ($urandom_range(3) != 0);
            if8.clear     = ($urandom_range(63) == 0);
            if8.dir_we    = 1'b0;
            if (!m_valid[1] && m_idx[1] == 0 && $urandom_range(1) == 0) begin
                if8.dir_we    = 1'b1;
                if8.dir_addr  = 3'($urandom_range(7));
                if8.dir_wdata = 8'($urandom_range(255));
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sobol_rng.md
# sobol_rng

Streaming low-discrepancy (Sobol) sequence generator: the producer side of the least-significant-zero index path. It keeps an `INWD`-bit sample counter and finds the index of the counter's least significant zero. It XORs the selected direction vector into the running sample and offers one sample per accepted transfer on a valid/ready stream. It feeds the unary/stochastic comparators of the FC datapath, and its direction vectors are runtime-programmable, so one block serves any Sobol dimension.

## Interface
Parameters:
- `INWD`, 8, sample and counter width; legal range 3..10.
- `LOGINWD`, `$clog2(INWD)`, width of the direction-vector index.

Ports:
- `clk` input 1: the single clock.
- `rst` input 1: reset, synchronous and active-high.
- `en` input 1: request sample generation.
- `clear` input 1: synchronous restart of the sequence.
- `dir_we` input 1: direction-vector write strobe.
- `dir_addr` input `LOGINWD`: direction-vector index.
- `dir_wdata` input `INWD`: direction-vector value.
- `out_valid` output 1: sample valid.
- `out_ready` input 1: consumer accepts the sample.
- `out_rnd` output `INWD`: current sample.
- `out_last` output 1: this sample is the last one of the 2^`INWD` period.

## Operation
- State:
  - counter `cnt` (`INWD` bits), sample `rnd` (`INWD` bits), `out_valid` flag.
  - Direction table `dir[0..INWD-1]` (`INWD` bits each).
- Reset values: `cnt`=0, `rnd`=0, `out_valid`=0, `out_last`=0.
- Reset value of the direction table (van der Corput): `dir[k]` = 1 << (`INWD`-1-k).
- `out_rnd` = `rnd`, `out_last` = (`cnt` == all ones) && `out_valid`.
- Next-sample rule:
  - `lsz` = index of the least significant 0 bit of `cnt`.
  - If `cnt` is all ones: `rnd_next`=0 and `cnt_next`=0 (period wrap).
  - Otherwise: `rnd_next` = `rnd` ^ `dir[lsz]` and `cnt_next` = `cnt`+1.
- Handshake; transfer = `out_valid` && `out_ready`:
  - Idle (`out_valid`=0) with `en`=1: `out_valid`<=1 and the current `rnd` is presented; no advance.
  - On a transfer: `rnd`<=`rnd_next`, `cnt`<=`cnt_next`, `out_valid`<=`en`.
  - While `out_valid`=1 without a transfer: `out_rnd`, `out_last` and `out_valid` hold stable. `out_valid` never drops before acceptance, even if `en` falls.
- `clear`:
  - Sets `cnt`=0, `rnd`=0, `out_valid`=0 and overrides a same-cycle transfer.
  - The direction table is unaffected.
- Direction writes:
  - `dir_we`=1 writes `dir[dir_addr]`<=`dir_wdata`.
  - A `dir_addr` >= `INWD` is ignored.
  - A same-cycle transfer uses the old table value; the write is visible from the next cycle.
  - Writes are legal at any time; reprogramming mid-sequence is software's responsibility.
- Priority: `rst` > `clear` > transfer/idle-start.

## Timing
- First sample: `out_valid` rises 1 cycle after `en`=1 is sampled from idle.
- Throughput: with `en` and `out_ready` held high, one new sample per cycle; no bubbles.
- Next-sample logic (least-significant-zero search, table mux, XOR) is combinational from registered state; `out_*` come directly from registers.
- `rst` asserted mid-stream: all outputs return to their reset values at the next edge and the direction table returns to van der Corput.
- Period: exactly 2^`INWD` samples, then the sequence repeats from 0; `out_last` is high on the final sample of each period.

## Structure
- Shared package (existing defines package): `INWD`/`LOGINWD` defaults, a `dir_vec_t` typedef, and the van der Corput reset-table constant function.
- One sub-module: reuse `LSZ` for the least-significant-zero index of `cnt`. The all-ones wrap is detected separately, because `LSZ` returns 0 in that case.
- The rest is a single module: handshake register, counter, and direction-table register file.

## Test plan
Scenarios 1-5 use `INWD`=3.
1. Reset, then `en`=1 and `out_ready`=1 held -> samples 0,4,6,2,3,7,5,1,0,4,...; `out_last`=1 only on the value 1.
2. Backpressure: `out_ready`=0 for 3 cycles at sample 6 -> `out_rnd`=6 and `out_valid`=1 held; the next accepted sample is 2.
3. Program `dir`={001,010,100} while idle, then run -> 0,1,3,2,6,7,5,4,0; a write with `dir_addr`=3 is ignored.
4. `clear` in the same cycle as a transfer at sample 7 -> `out_valid`=0 next cycle; restart yields 0,4,6,...
5. `rst` mid-stream after writing custom dirs -> outputs 0 and the van der Corput sequence resumes.
6. `en` dropped while `out_valid`=1 and `out_ready`=0 -> valid held until accepted, then low; `INWD`=8 run checks 256 distinct values per period.
